// File: rtl/tiny_dnn_seq_if.sv
// Request/handshake bundle between the layer controller, the tiny_dnn_seq
// sequencer and the MAC core it drives.
interface tiny_dnn_seq_if #(
  parameter int AW = 10
);
  logic          start;
  logic [AW:0]   n_taps;
  logic          use_bias;
  logic          ld_start;
  logic [AW:0]   ld_len;
  logic          ld_bias;
  logic          ld_valid;
  logic          ld_ready;
  logic          write;
  logic          bwrite;
  logic [AW-1:0] wa;
  logic          init;
  logic          exec;
  logic          bias;
  logic [AW-1:0] ra;
  logic          d_rd;
  logic          update;
  logic          done;
  logic          busy;

  modport master (
    output start, n_taps, use_bias, ld_start, ld_len, ld_bias, ld_valid,
    input  ld_ready, write, bwrite, wa, init, exec, bias, ra, d_rd,
           update, done, busy
  );

  modport slave (
    input  start, n_taps, use_bias, ld_start, ld_len, ld_bias, ld_valid,
    output ld_ready, write, bwrite, wa, init, exec, bias, ra, d_rd,
           update, done, busy
  );
endinterface

// File: rtl/tiny_dnn_seq.sv
// Sequencer for one tiny_dnn_core MAC lane: weight-load streaming and
// dot-product control, hiding the core's 3-stage accumulate pipeline.
module tiny_dnn_seq #(
  parameter int F_SIZE = 1024,
  parameter int AW     = $clog2(F_SIZE)
) (
  input  logic         clk,
  input  logic         rst_n,
  tiny_dnn_seq_if.slave bus
);

  localparam logic [AW-1:0] LAST = AW'(F_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_INIT, S_EXEC, S_BIAS, S_DRAIN, S_UPD
  } state_e;

  state_e        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] len, len_nxt;    // tap count or weight count of the current job
  logic          flag, flag_nxt;  // use_bias or ld_bias of the current job
  logic          need_w, need_b, xfer;

  // Slot F_SIZE-1 belongs to the bias, so job lengths saturate one below it.
  function automatic logic [AW-1:0] clamp(input logic [AW:0] v);
    return (v > (AW+1)'(F_SIZE - 1)) ? LAST : v[AW-1:0];
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, matching real hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      len   <= '0;
      flag  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      len   <= len_nxt;
      flag  <= flag_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    len_nxt      = len;
    flag_nxt     = flag;
    need_w       = (cnt < len);
    need_b       = (cnt == len) && flag;
    xfer         = 1'b0;
    bus.ld_ready = 1'b0;
    bus.write    = 1'b0;
    bus.bwrite   = 1'b0;
    bus.wa       = '0;
    bus.init     = 1'b0;
    bus.exec     = 1'b0;
    bus.bias     = 1'b0;
    bus.ra       = '0;
    bus.update   = 1'b0;

    unique case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (bus.start) begin
          len_nxt   = clamp(bus.n_taps);
          flag_nxt  = bus.use_bias;
          state_nxt = S_INIT;
        end else if (bus.ld_start) begin
          len_nxt   = clamp(bus.ld_len);
          flag_nxt  = bus.ld_bias;
          state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        // Ready only while a word is still owed, so an empty load writes nothing.
        bus.ld_ready = need_w | need_b;
        xfer         = bus.ld_valid & (need_w | need_b);
        bus.write    = xfer;
        bus.bwrite   = xfer & need_b;
        bus.wa       = need_b ? LAST : cnt;
        if (!(need_w | need_b)) begin
          state_nxt = S_IDLE;
        end else if (xfer) begin
          if (need_b) begin
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
            if ((cnt == len - 1'b1) && !flag) state_nxt = S_IDLE;
          end
        end
      end

      S_INIT: begin
        bus.init  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = (len != '0) ? S_EXEC : (flag ? S_BIAS : S_DRAIN);
      end

      S_EXEC: begin
        bus.exec = 1'b1;
        bus.ra   = cnt;
        if (cnt == len - 1'b1) begin
          cnt_nxt   = '0;
          state_nxt = flag ? S_BIAS : S_DRAIN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      S_BIAS: begin
        bus.bias  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = S_DRAIN;
      end

      // Two idle cycles let the last step walk exec1 -> exec2 -> suml.
      S_DRAIN: begin
        if (cnt[0]) begin
          cnt_nxt   = '0;
          state_nxt = S_UPD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      S_UPD: begin
        bus.update = 1'b1;
        state_nxt  = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.d_rd = bus.exec;
  assign bus.done = bus.update;
  assign bus.busy = (state != S_IDLE);

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Scoreboard bench for tiny_dnn_seq: directed jobs push expected core events,
// a negedge monitor pops and compares them; a small core model tracks the sum.
module tb_tiny_dnn_seq;
  localparam int F_SIZE = 1024;
  localparam int AW     = 10;

  typedef enum logic [2:0] {EV_WR, EV_BWR, EV_INIT, EV_EXEC, EV_BIAS, EV_UPD} ev_e;
  typedef struct {
    ev_e kind;
    int  addr;
    int  cyc;   // -1: timing not checked
    int  sum;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tiny_dnn_seq_if #(.AW(AW)) bus ();
  tiny_dnn_seq #(.F_SIZE(F_SIZE), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc   = 0;
  ev_t exp_q[$];

  // Core/buffer model; values are scaled by 2 so 0.5 becomes the integer 1.
  int   w_mem [F_SIZE];
  int   d_mem [F_SIZE];
  int   ld_words [4] = '{2, 4, 6, 1};
  int   wd   = 0;
  int   acc  = 0;
  int   w_q  = 0;
  int   d_q  = 0;
  logic exec_q = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    int nxt;
    cyc <= cyc + 1;
    if (bus.write) begin
      if (bus.bwrite) w_mem[F_SIZE-1] <= wd;
      else            w_mem[bus.wa]   <= wd;
    end
    exec_q <= bus.exec;
    w_q    <= w_mem[bus.ra];
    if (bus.d_rd) d_q <= d_mem[bus.ra];
    nxt = acc;
    if (exec_q)   nxt = nxt + w_q * d_q;
    if (bus.bias) nxt = nxt + w_mem[F_SIZE-1];
    if (bus.init) nxt = 0;
    acc <= nxt;
  end

  // Monitor: every core-visible strobe must match the head of the queue.
  always @(negedge clk) begin
    ev_t e;
    ev_e k;
    if (rst_n && (bus.write || bus.init || bus.exec || bus.bias || bus.update)) begin
      check("one_strobe", $countones({bus.write, bus.init, bus.exec, bus.bias, bus.update}), 1);
      if (bus.write)     k = bus.bwrite ? EV_BWR : EV_WR;
      else if (bus.init) k = EV_INIT;
      else if (bus.exec) k = EV_EXEC;
      else if (bus.bias) k = EV_BIAS;
      else               k = EV_UPD;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", k, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", int'(k), int'(e.kind));
        if (e.kind == EV_WR)   check("wa", int'(bus.wa), e.addr);
        if (e.kind == EV_EXEC) begin
          check("ra", int'(bus.ra), e.addr);
          check("d_rd", int'(bus.d_rd), 1);
        end
        if (e.cyc >= 0) check("event_cycle", cyc, e.cyc);
        if (e.kind == EV_UPD) begin
          check("sum", acc, e.sum);
          check("done", int'(bus.done), 1);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.n_taps   = '0;
    bus.use_bias = 1'b0;
    bus.ld_start = 1'b0;
    bus.ld_len   = '0;
    bus.ld_bias  = 1'b0;
    bus.ld_valid = 1'b0;
  endtask

  task automatic do_load(input int len, input bit b, input int gap_after);
    int total = len + (b ? 1 : 0);
    for (int i = 0; i < len; i++) exp_q.push_back('{EV_WR, i, -1, 0});
    if (b) exp_q.push_back('{EV_BWR, 0, -1, 0});
    @(posedge clk); #1;
    bus.ld_start = 1'b1;
    bus.ld_len   = (AW+1)'(len);
    bus.ld_bias  = b;
    @(posedge clk); #1;
    bus.ld_start = 1'b0;
    for (int i = 0; i < total; i++) begin
      if (i == gap_after) begin
        bus.ld_valid = 1'b0;
        #1;
        check("gap_wa", int'(bus.wa), i);
        check("gap_ready", int'(bus.ld_ready), 1);
        @(posedge clk); #1;
      end
      bus.ld_valid = 1'b1;
      wd           = ld_words[i];
      @(posedge clk); #1;
    end
    bus.ld_valid = 1'b0;
  endtask

  task automatic do_dot(input int n_taps, input bit ub, input int exp_sum, input bit with_ld);
    int n = (n_taps > F_SIZE - 1) ? F_SIZE - 1 : n_taps;
    @(posedge clk); #1;
    exp_q.push_back('{EV_INIT, 0, cyc + 1, 0});
    for (int k = 0; k < n; k++) exp_q.push_back('{EV_EXEC, k, cyc + 2 + k, 0});
    if (ub) exp_q.push_back('{EV_BIAS, 0, cyc + 2 + n, 0});
    exp_q.push_back('{EV_UPD, 0, cyc + 4 + n + (ub ? 1 : 0), exp_sum});
    bus.start    = 1'b1;
    bus.n_taps   = (AW+1)'(n_taps);
    bus.use_bias = ub;
    bus.ld_start = with_ld;
    bus.ld_len   = (AW+1)'(3);
    bus.ld_bias  = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.ld_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d events pending, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    check({tag, "_busy_end"}, int'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    for (int i = 0; i < 3; i++) d_mem[i] = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ready", int'(bus.ld_ready), 0);
    check("rst_strobes", int'({bus.write, bus.bwrite, bus.init, bus.exec, bus.bias, bus.update, bus.done}), 0);
    check("rst_ra_wa", int'({bus.ra, bus.wa}), 0);
    rst_n = 1'b1;

    // Weight load with a one-cycle valid gap, then the bias word.
    do_load(3, 1'b1, 1);
    wait_idle(10, "load");

    // Empty load: one busy cycle, valid held high, no write allowed.
    @(posedge clk); #1;
    bus.ld_start = 1'b1;
    bus.ld_len   = '0;
    bus.ld_bias  = 1'b0;
    bus.ld_valid = 1'b1;
    @(posedge clk); #1;
    bus.ld_start = 1'b0;
    check("empty_load_busy", int'(bus.busy), 1);
    @(posedge clk); #1;
    check("empty_load_done", int'(bus.busy), 0);
    bus.ld_valid = 1'b0;

    // W=[1,2,3], bias 0.5, d=1: sum 6.5, update in cycle 8.
    do_dot(3, 1'b1, 13, 1'b0);
    check("busy_c1", int'(bus.busy), 1);
    wait_idle(20, "dot3b");

    do_dot(0, 1'b0, 0, 1'b0);
    wait_idle(20, "dot0");
    do_dot(0, 1'b1, 1, 1'b0);
    wait_idle(20, "dot0b");

    // A second start while busy is ignored.
    do_dot(3, 1'b0, 12, 1'b0);
    bus.start  = 1'b1;
    bus.n_taps = (AW+1)'(5);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle(20, "busy_start");

    // start beats ld_start; any write would surface as an unexpected event.
    do_dot(2, 1'b0, 6, 1'b1);
    wait_idle(20, "both_start");

    // n_taps = F_SIZE clamps to 1023 taps, ra 0..1022.
    do_dot(F_SIZE, 1'b0, 12, 1'b0);
    wait_idle(1100, "clamp");

    // Reset in the middle of EXEC, then a normal job.
    do_dot(10, 1'b0, 12, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_exec", int'(bus.exec), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_exec", int'(bus.exec), 0);
    check("rst_mid_busy", int'(bus.busy), 0);
    check("rst_mid_ra", int'(bus.ra), 0);
    check("rst_mid_drd", int'(bus.d_rd), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_busy", int'(bus.busy), 0);
    do_dot(3, 1'b1, 13, 1'b0);
    wait_idle(20, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
